// File: rtl/cache_mem_pkg.sv
// Shared types and defaults for the cache main-memory responder.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
package cache_mem_pkg;

    localparam int MEM_ADDR_W  = 13;
    localparam int MEM_LINE_W  = 64;
    localparam int MEM_LATENCY = 5;
    localparam int CNT_W       = 4;
    localparam int STAT_W      = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    // Request fields captured at accept and used for the rest of the transaction
    typedef struct packed {
        logic                  we;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_LINE_W-1:0] wdata;
    } mem_req_t;

    // State entered on accept: a single-cycle latency skips the wait phase entirely
    function automatic mem_state_t state_after_accept(input int latency);
        return (latency == 1) ? RESP : WAIT;
    endfunction

    // Saturating increment for the statistics counters
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/cache_mem_array.sv
// Single-port synchronous line store, 2**ADDR_W x LINE_W, contents never reset.
// Latency: write commits on the enabled edge; read data is registered, valid the cycle after re.
// Backpressure: none; caller sequences we/re, rdata holds between reads.
module cache_mem_array
    import cache_mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int LINE_W = MEM_LINE_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LINE_W-1:0] wdata,
    output logic [LINE_W-1:0] rdata
);

    logic [LINE_W-1:0] mem [2**ADDR_W];

    // Write port and registered read port share one address
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/cache_mem_responder.sv
// Main-memory model answering cache line-fill / write-back requests, one at a time.
// Latency: accept at edge T -> rsp_valid pulse in the cycle after edge T+LATENCY; next accept at T+LATENCY+1.
// Backpressure: req_ready low while a request is in flight; req_valid is ignored then (no queue).
// Optional CACHE_MEM_STATS_EN adds saturating rd_count/wr_count outputs.
module cache_mem_responder
    import cache_mem_pkg::*;
#(
    parameter int ADDR_W  = MEM_ADDR_W,
    parameter int LINE_W  = MEM_LINE_W,
    parameter int LATENCY = MEM_LATENCY
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LINE_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [LINE_W-1:0] rsp_rdata,
    output logic              busy
`ifdef CACHE_MEM_STATS_EN
    ,
    output logic [STAT_W-1:0] rd_count,
    output logic [STAT_W-1:0] wr_count
`endif
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
    localparam bit               LAT_ONE  = (LATENCY == 1);

    mem_state_t        state;
    logic [CNT_W-1:0]  cnt;
    mem_req_t          lat_req;

    logic              access_now;
    logic              acc_we;
    logic              arr_we;
    logic              arr_re;
    logic [ADDR_W-1:0] arr_addr;
    logic [LINE_W-1:0] arr_wdata;
    logic [LINE_W-1:0] arr_rdata;

    // Pick the access moment and its fields: on the accept edge for single-cycle
    // latency (live request), otherwise on the last wait cycle (latched request).
    // Gating with rst_n keeps a reset edge from committing a pending write.
    always_comb begin
        access_now = 1'b0;
        acc_we     = lat_req.we;
        arr_addr   = lat_req.addr;
        arr_wdata  = lat_req.wdata;
        if (state == IDLE) begin
            access_now = LAT_ONE && req_valid;
            acc_we     = req_we;
            arr_addr   = req_addr;
            arr_wdata  = req_wdata;
        end else if (state == WAIT) begin
            access_now = (cnt == CNT_W'(1));
        end
        arr_we = rst_n && access_now && acc_we;
        arr_re = rst_n && access_now && !acc_we;
    end

    cache_mem_array #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .re    (arr_re),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    // Request FSM: accept, count down the access latency, pulse the response
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_req   <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_req.we    <= req_we;
                        lat_req.addr  <= req_addr;
                        lat_req.wdata <= req_wdata;
                        cnt           <= CNT_INIT;
                        req_ready     <= 1'b0;
                        state         <= state_after_accept(LATENCY);
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= lat_req.we ? '0 : arr_rdata;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign busy = ~req_ready;

`ifdef CACHE_MEM_STATS_EN
    // Count completed reads and writes on their response cycle, saturating
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (state == RESP) begin
            if (lat_req.we) begin
                wr_count <= sat_inc(wr_count);
            end else begin
                rd_count <= sat_inc(rd_count);
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_mem_responder.sv
// Bench for the cache memory responder: a LATENCY=5 and a LATENCY=1 instance.
// Latency: checked per transaction against the configured latency.
// Backpressure: busy-rejection and held-request acceptance checked by hand sequence.
module tb_cache_mem_responder;

    localparam int AW = 13;
    localparam int LW = 64;

    logic          clk;
    logic          rst_n;
    logic          req_valid [2];
    logic          req_we    [2];
    logic [AW-1:0] req_addr  [2];
    logic [LW-1:0] req_wdata [2];
    logic          req_ready [2];
    logic          rsp_valid [2];
    logic [LW-1:0] rsp_rdata [2];
    logic          busy      [2];
`ifdef CACHE_MEM_STATS_EN
    logic [15:0]   rd_count  [2];
    logic [15:0]   wr_count  [2];
`endif

    int n_chk  = 0;
    int n_fail = 0;

    // Reference memory: key = instance*8192 + line address
    logic [LW-1:0] mdl [int];

    cache_mem_responder #(.ADDR_W(AW), .LINE_W(LW), .LATENCY(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_we(req_we[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .req_ready(req_ready[0]), .rsp_valid(rsp_valid[0]),
        .rsp_rdata(rsp_rdata[0]), .busy(busy[0])
`ifdef CACHE_MEM_STATS_EN
        , .rd_count(rd_count[0]), .wr_count(wr_count[0])
`endif
    );

    cache_mem_responder #(.ADDR_W(AW), .LINE_W(LW), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_we(req_we[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .req_ready(req_ready[1]), .rsp_valid(rsp_valid[1]),
        .rsp_rdata(rsp_rdata[1]), .busy(busy[1])
`ifdef CACHE_MEM_STATS_EN
        , .rd_count(rd_count[1]), .wr_count(wr_count[1])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 5 : 1;
    endfunction

    task automatic chk(input string nm, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // One complete transaction on instance d, checked for latency, single pulse and data
    task automatic txn(input int d, input logic we, input logic [AW-1:0] a,
                       input logic [LW-1:0] wd, input bit flip,
                       input logic [LW-1:0] exp, input string nm);
        int w;
        int first;
        int pulses;
        logic [LW-1:0] got;
        w = 0;
        while (!req_ready[d] && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (w == 50) chk({nm, "_ready_timeout"}, 64'(req_ready[d]), 64'd1);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        if (flip) begin
            req_addr[d]  = a ^ 13'h1;
            req_wdata[d] = ~wd;
            req_we[d]    = ~we;
        end
        first  = -1;
        pulses = 0;
        got    = '0;
        for (int k = 1; k <= lat_of(d) + 3; k++) begin
            @(posedge clk); #1;
            if (rsp_valid[d]) begin
                pulses++;
                if (first < 0) first = k;
                got = rsp_rdata[d];
            end
        end
        chk({nm, "_latency"}, 64'(first), 64'(lat_of(d)));
        chk({nm, "_pulses"}, 64'(pulses), 64'd1);
        chk({nm, "_rdata"}, got, exp);
        if (we) mdl[d * 8192 + int'(a)] = wd;
    endtask

    typedef struct {
        int            d;
        logic          we;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
        bit            flip;
        logic [LW-1:0] exp;
    } vec_t;

    vec_t vecs [9];

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
        logic [LW-1:0] exp;
    } op_t;

    op_t b2b [5];

    initial begin
        int pulses;
        int pk [2];
        logic [LW-1:0] pd [2];

        vecs[0] = '{0, 1'b1, 13'h0A5, 64'h1111_2222_3333_4444, 1'b0, 64'h0};
        vecs[1] = '{0, 1'b0, 13'h0A5, 64'h0,                   1'b0, 64'h1111_2222_3333_4444};
        vecs[2] = '{0, 1'b1, 13'h021, 64'hAAAA_0000_0000_0021, 1'b0, 64'h0};
        vecs[3] = '{0, 1'b1, 13'h020, 64'h5555_0000_0000_0020, 1'b1, 64'h0};
        vecs[4] = '{0, 1'b0, 13'h020, 64'h0,                   1'b0, 64'h5555_0000_0000_0020};
        vecs[5] = '{0, 1'b0, 13'h021, 64'h0,                   1'b0, 64'hAAAA_0000_0000_0021};
        vecs[6] = '{1, 1'b1, 13'h0A5, 64'h0123_4567_89AB_CDEF, 1'b0, 64'h0};
        vecs[7] = '{1, 1'b0, 13'h0A5, 64'h0,                   1'b0, 64'h0123_4567_89AB_CDEF};
        vecs[8] = '{0, 1'b0, 13'h0A5, 64'h0,                   1'b0, 64'h1111_2222_3333_4444};

        b2b[0] = '{1'b1, 13'h040, 64'hA0A0_0000_0000_0040, 64'h0};
        b2b[1] = '{1'b1, 13'h041, 64'hB1B1_0000_0000_0041, 64'h0};
        b2b[2] = '{1'b0, 13'h040, 64'h0, 64'hA0A0_0000_0000_0040};
        b2b[3] = '{1'b0, 13'h041, 64'h0, 64'hB1B1_0000_0000_0041};
        b2b[4] = '{1'b0, 13'h040, 64'h0, 64'hA0A0_0000_0000_0040};

        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_we[d]    = 1'b0;
            req_addr[d]  = '0;
            req_wdata[d] = '0;
        end

        // Reset held for two cycles
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset_ready%0d", d), 64'(req_ready[d]), 64'd1);
            chk($sformatf("reset_busy%0d", d), 64'(busy[d]), 64'd0);
            chk($sformatf("reset_rsp_valid%0d", d), 64'(rsp_valid[d]), 64'd0);
            chk($sformatf("reset_rsp_rdata%0d", d), rsp_rdata[d], 64'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back on the single-cycle instance: 2-cycle spacing, response 1 cycle after accept
        for (int i = 0; i < 5; i++) begin
            req_valid[1] = 1'b1;
            req_we[1]    = b2b[i].we;
            req_addr[1]  = b2b[i].addr;
            req_wdata[1] = b2b[i].wdata;
            @(posedge clk); #1;
            chk($sformatf("b2b%0d_rsp_early", i), 64'(rsp_valid[1]), 64'd0);
            chk($sformatf("b2b%0d_busy_ready", i), 64'(req_ready[1]), 64'd0);
            @(posedge clk); #1;
            chk($sformatf("b2b%0d_rsp", i), 64'(rsp_valid[1]), 64'd1);
            chk($sformatf("b2b%0d_rdata", i), rsp_rdata[1], b2b[i].exp);
            if (b2b[i].we) mdl[8192 + int'(b2b[i].addr)] = b2b[i].wdata;
        end
        req_valid[1] = 1'b0;
`ifdef CACHE_MEM_STATS_EN
        chk("stats_rd1", 64'(rd_count[1]), 64'd3);
        chk("stats_wr1", 64'(wr_count[1]), 64'd2);
        chk("stats_rd0", 64'(rd_count[0]), 64'd0);
`endif
        @(posedge clk); #1;

        // Table of directed transactions
        foreach (vecs[i]) begin
            txn(vecs[i].d, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].flip,
                vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Busy rejection: a second request raised 2 cycles after accept is held until IDLE
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 13'h010;
        req_wdata[0] = 64'hCAFE_F00D_0000_0010;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b0;
        pulses = 0;
        for (int k = 3; k <= 14; k++) begin
            @(posedge clk); #1;
            if (k == 3) chk("busy_ready_low", 64'(req_ready[0]), 64'd0);
            if (k == 4) chk("busy_flag_high", 64'(busy[0]), 64'd1);
            if (rsp_valid[0]) begin
                if (pulses < 2) begin
                    pk[pulses] = k;
                    pd[pulses] = rsp_rdata[0];
                end
                pulses++;
            end
            if (k == 6) req_valid[0] = 1'b0;
        end
        chk("busy_pulses", 64'(pulses), 64'd2);
        if (pulses >= 2) begin
            chk("busy_first_at", 64'(pk[0]), 64'd5);
            chk("busy_first_rdata", pd[0], 64'd0);
            chk("busy_second_at", 64'(pk[1]), 64'd11);
            chk("busy_second_rdata", pd[1], 64'hCAFE_F00D_0000_0010);
        end
        mdl[13'h010] = 64'hCAFE_F00D_0000_0010;

        // Reset in the middle of a write aborts it
        txn(0, 1'b1, 13'h1FF, 64'h0, 1'b0, 64'h0, "rst_prewrite");
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 13'h1FF;
        req_wdata[0] = 64'hDEAD_BEEF_0000_0001;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        pulses = 0;
        for (int k = 3; k <= 10; k++) begin
            @(posedge clk); #1;
            if (k == 4) rst_n = 1'b1;
            if (rsp_valid[0]) pulses++;
        end
        chk("rst_mid_no_rsp", 64'(pulses), 64'd0);
        chk("rst_mid_ready", 64'(req_ready[0]), 64'd1);
        txn(0, 1'b0, 13'h1FF, 64'h0, 1'b0, 64'h0, "rst_mid_readback");

        // Randomized traffic against the reference memory
        for (int i = 0; i < 8; i++) begin
            for (int d = 0; d < 2; d++) begin
                txn(d, 1'b1, 13'h300 + 13'(i), {$urandom, $urandom}, 1'b0, 64'h0,
                    $sformatf("rnd_init%0d_%0d", d, i));
            end
        end
        for (int i = 0; i < 40; i++) begin
            int d;
            logic we;
            logic [AW-1:0] a;
            logic [LW-1:0] wd;
            logic [LW-1:0] exp;
            d   = int'($urandom_range(0, 1));
            we  = 1'($urandom_range(0, 1));
            a   = 13'h300 + 13'($urandom_range(0, 7));
            wd  = {$urandom, $urandom};
            exp = we ? 64'h0 : mdl[d * 8192 + int'(a)];
            txn(d, we, a, wd, 1'($urandom_range(0, 1)), exp, $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
